// File: rtl/conv3x3_prog_filter.sv
// Pipelined 3x3 convolution with runtime-programmable signed kernel, shift and output clamp.
// Optional build macro CONV3_ROUND_EN: round-half-up before the right shift.
module conv3x3_prog_filter #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEF_WIDTH  = 4,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in1,
  input  logic [DATA_WIDTH-1:0]  in2,
  input  logic [DATA_WIDTH-1:0]  in3,
  input  logic [DATA_WIDTH-1:0]  in4,
  input  logic [DATA_WIDTH-1:0]  in5,
  input  logic [DATA_WIDTH-1:0]  in6,
  input  logic [DATA_WIDTH-1:0]  in7,
  input  logic [DATA_WIDTH-1:0]  in8,
  input  logic [DATA_WIDTH-1:0]  in9,
  input  logic                   coef_we,
  input  logic [3:0]             coef_addr,
  input  logic [COEF_WIDTH-1:0]  coef_wdata,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   sat_flag
);
  localparam int PW    = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int RW    = PW + 2;
  localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + 5;
`ifdef CONV3_ROUND_EN
  // Headroom for the rounding constant at the largest possible shift.
  localparam int RND_W = ACC_W + (1 << SHIFT_WIDTH);
`else
  localparam int RND_W = ACC_W;
`endif
  localparam logic signed [RND_W-1:0] MAX_PIX = RND_W'((1 << DATA_WIDTH) - 1);

  function automatic logic [RW-1:0] ext_p(input logic [PW-1:0] v);
    return {{(RW-PW){v[PW-1]}}, v};
  endfunction

  function automatic logic [ACC_W-1:0] ext_r(input logic [RW-1:0] v);
    return {{(ACC_W-RW){v[RW-1]}}, v};
  endfunction

  logic [DATA_WIDTH-1:0]  pix [9];
  logic [PW-1:0]          prod [9];
  logic [RW-1:0]          rows [3];
  logic [SHIFT_WIDTH-1:0] shift_reg;
  logic                   v1_reg;
  logic                   v2_reg;
  logic [ACC_W-1:0]       acc;
  logic signed [RND_W-1:0] biased;
  logic signed [RND_W-1:0] shifted;
  logic [DATA_WIDTH-1:0]  data_next;
  logic                   sat_next;

  assign pix[0] = in1;
  assign pix[1] = in2;
  assign pix[2] = in3;
  assign pix[3] = in4;
  assign pix[4] = in5;
  assign pix[5] = in6;
  assign pix[6] = in7;
  assign pix[7] = in8;
  assign pix[8] = in9;

  // Each tap owns its coefficient; reset value is the 1-2-1/2-4-2/1-2-1 Gaussian.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      localparam logic [COEF_WIDTH-1:0] K_RST = (gi == 4) ? COEF_WIDTH'(4) :
                                                ((gi % 2) == 1) ? COEF_WIDTH'(2) : COEF_WIDTH'(1);
      logic [COEF_WIDTH-1:0] k_reg;
      logic [PW-1:0]         p_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          k_reg <= K_RST;
          p_reg <= '0;
        end else begin
          if (coef_we && coef_addr == 4'(gi))
            k_reg <= coef_wdata;
          if (enable)
            p_reg <= $signed({{(PW-DATA_WIDTH){1'b0}}, pix[gi]}) *
                     $signed({{(PW-COEF_WIDTH){k_reg[COEF_WIDTH-1]}}, k_reg});
        end
      end
      assign prod[gi] = p_reg;
    end

    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [RW-1:0] r_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_reg <= '0;
        else if (enable)
          r_reg <= ext_p(prod[3*gi]) + ext_p(prod[3*gi+1]) + ext_p(prod[3*gi+2]);
      end
      assign rows[gi] = r_reg;
    end
  endgenerate

  assign acc = ext_r(rows[0]) + ext_r(rows[1]) + ext_r(rows[2]);

`ifdef CONV3_ROUND_EN
  logic [RND_W-1:0] half;
  assign half   = (shift_reg == '0) ? '0 :
                  ({{(RND_W-1){1'b0}}, 1'b1} << (shift_reg - SHIFT_WIDTH'(1)));
  assign biased = {{(RND_W-ACC_W){acc[ACC_W-1]}}, acc} + half;
`else
  assign biased = acc;
`endif

  // Shift is read live, so samples already past S1 see a newly written shift.
  assign shifted = biased >>> shift_reg;

  always_comb begin
    data_next = shifted[DATA_WIDTH-1:0];
    sat_next  = 1'b0;
    if (shifted[RND_W-1]) begin
      data_next = '0;
      sat_next  = 1'b1;
    end else if (shifted > MAX_PIX) begin
      data_next = '1;
      sat_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= SHIFT_WIDTH'(4);
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (coef_we && coef_addr == 4'd9)
        shift_reg <= coef_wdata[SHIFT_WIDTH-1:0];
      if (enable) begin
        v1_reg    <= in_valid;
        v2_reg    <= v1_reg;
        out_valid <= v2_reg;
        if (v2_reg) begin
          data_out <= data_next;
          sat_flag <= sat_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_prog_filter.sv
// Self-checking bench for conv3x3_prog_filter: table vectors, hand sequences and random
// streams against a behavioural model (delay of 3 enabled cycles, plain integer convolution).
module tb_conv3x3_prog_filter;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       in_valid;
  logic [7:0] pix [9];
  logic       coef_we;
  logic [3:0] coef_addr;
  logic [3:0] coef_wdata;
  logic       out_valid;
  logic [7:0] data_out;
  logic       sat_flag;

  always #5 clk = ~clk;

  conv3x3_prog_filter dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .in1(pix[0]), .in2(pix[1]), .in3(pix[2]), .in4(pix[3]), .in5(pix[4]),
    .in6(pix[5]), .in7(pix[6]), .in8(pix[7]), .in9(pix[8]),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .data_out(data_out), .sat_flag(sat_flag)
  );

`ifdef CONV3_ROUND_EN
  localparam int G255 = 64;
`else
  localparam int G255 = 63;
`endif

  typedef struct {
    bit v;
    int d;
    bit s;
  } res_t;

  typedef struct {
    int    kern;   // 0 = Gaussian, 1 = sharpen
    int    c;      // centre
    int    e;      // edge neighbours
    int    k;      // corners
    int    ed;     // expected data_out
    int    es;     // expected sat_flag
    string name;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  // Model state: current kernel/shift and the three-slot enabled-cycle delay.
  int   km [9];
  int   sm;
  res_t dl [3];
  bit   exp_ov;
  int   last_d;
  bit   last_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d, expected %0d", phase, name, act, exp);
    end
  endtask

  function automatic res_t ref_pixel();
    res_t r;
    int acc = 0;
    for (int i = 0; i < 9; i++) acc += int'(pix[i]) * km[i];
`ifdef CONV3_ROUND_EN
    if (sm > 0) acc += (1 << (sm - 1));
`endif
    acc = acc >>> sm;
    r.v = 1'b1;
    r.s = (acc < 0) || (acc > 255);
    r.d = (acc < 0) ? 0 : (acc > 255) ? 255 : acc;
    return r;
  endfunction

  task automatic model_reset();
    int g [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    for (int i = 0; i < 9; i++) km[i] = g[i];
    sm = 4;
    for (int i = 0; i < 3; i++) dl[i] = '{1'b0, 0, 1'b0};
    exp_ov = 1'b0;
    last_d = 0;
    last_s = 1'b0;
  endtask

  // One clock edge; the model consumes the inputs that were present at the edge.
  task automatic step(input bit chk);
    res_t nw;
    bit   en;
    en = enable;
    nw = '{1'b0, 0, 1'b0};
    if (in_valid) nw = ref_pixel();
    @(posedge clk);
    #1;
    if (en) begin
      dl[2] = dl[1];
      dl[1] = dl[0];
      dl[0] = nw;
      exp_ov = dl[2].v;
      if (dl[2].v) begin
        last_d = dl[2].d;
        last_s = dl[2].s;
      end
    end
    if (chk) begin
      check("out_valid", out_valid, exp_ov);
      check("data_out", data_out, last_d);
      check("sat_flag", sat_flag, last_s);
    end
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = 4'(addr);
    coef_wdata = 4'(val);
    step(1);
    if (addr < 9) km[addr] = val;
    else if (addr == 9) sm = val & 15;
    coef_we = 1'b0;
  endtask

  task automatic program_kernel(input int id);
    int g [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    int s [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    for (int i = 0; i < 9; i++) write_coef(i, (id == 0) ? g[i] : s[i]);
    write_coef(9, (id == 0) ? 4 : 0);
  endtask

  task automatic set_pix(input int c, input int e, input int k);
    for (int i = 0; i < 9; i++)
      pix[i] = 8'((i == 4) ? c : ((i % 2) == 1) ? e : k);
  endtask

  task automatic set_uniform(input int v);
    for (int i = 0; i < 9; i++) pix[i] = 8'(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   cur_kern;
    int   got [$];

    vecs[0] = '{0, 100, 100, 100, 100, 0, "gauss_all100"};
    vecs[1] = '{0, 255, 0, 0, G255, 0, "gauss_centre255"};
    vecs[2] = '{0, 0, 0, 255, G255, 0, "gauss_corners255"};
    vecs[3] = '{1, 255, 0, 0, 255, 1, "sharp_centre255"};
    vecs[4] = '{1, 0, 255, 0, 0, 1, "sharp_edges255"};
    vecs[5] = '{1, 50, 50, 50, 50, 0, "sharp_all50"};

    // Reset state
    phase = "reset";
    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
    coef_addr = '0; coef_wdata = '0;
    set_uniform(0);
    repeat (3) @(posedge clk);
    #1;
    check("out_valid", out_valid, 0);
    check("data_out", data_out, 0);
    check("sat_flag", sat_flag, 0);
    rst = 1'b0;
    model_reset();

    // Table vectors: latency is exactly 3 enabled cycles
    cur_kern = 0;
    for (int n = 0; n < 6; n++) begin
      phase = vecs[n].name;
      if (vecs[n].kern != cur_kern) begin
        program_kernel(vecs[n].kern);
        cur_kern = vecs[n].kern;
      end
      set_pix(vecs[n].c, vecs[n].e, vecs[n].k);
      in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      step(1);
      check("early_valid", out_valid, 0);
      step(1);
      check("valid", out_valid, 1);
      check("data", data_out, vecs[n].ed);
      check("sat", sat_flag, vecs[n].es);
      $display("vector %s: data_out=%0d sat=%0d", vecs[n].name, data_out, sat_flag);
      step(1);
    end

    // Stall mid-stream: six samples, enable low for two cycles
    phase = "stall";
    program_kernel(0);
    begin
      int en_s [12] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
      int iv_s [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      int sm_s [12] = '{0, 1, 2, 3, 3, 3, 4, 5, 0, 0, 0, 0};
      for (int t = 0; t < 12; t++) begin
        enable   = en_s[t][0];
        in_valid = iv_s[t][0];
        set_uniform(10 * (sm_s[t] + 1));
        step(1);
        if (en_s[t] == 1 && out_valid) got.push_back(int'(data_out));
      end
    end
    enable = 1'b1;
    in_valid = 1'b0;
    check("count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("order", got[i], 10 * (i + 1));
    $display("stall: collected %0d results", got.size());

    // Same-edge coefficient write: sample uses the old kernel
    phase = "same_edge";
    set_uniform(16);
    in_valid = 1'b1; coef_we = 1'b1; coef_addr = 4'd4; coef_wdata = 4'd0;
    step(1);
    km[4] = 0;
    coef_we = 1'b0;
    step(1);
    in_valid = 1'b0;
    step(1);
    check("first", data_out, 16);
    step(1);
    check("second", data_out, 12);
    $display("same_edge: second result %0d", data_out);
    step(1);

    // Reset with two samples in flight; kernel must return to Gaussian
    phase = "rst_flight";
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_uniform(20 + 10 * i);
      step(1);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("out_valid", out_valid, 0);
    check("data_out", data_out, 0);
    check("sat_flag", sat_flag, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (5) step(1);
    set_pix(255, 0, 0);
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(1);
    step(1);
    check("gauss_back", data_out, G255);
    $display("rst_flight: post-reset centre255 -> %0d", data_out);

    // Random kernels, shifts, ignored addresses and random enable/valid
    for (int r = 0; r < 4; r++) begin
      phase = $sformatf("random%0d", r);
      enable = 1'b1;
      in_valid = 1'b0;
      repeat (3) step(1);
      for (int i = 0; i < 9; i++) write_coef(i, int'($urandom_range(0, 15)) - 8);
      write_coef(9, int'($urandom_range(0, 9)));
      write_coef(int'($urandom_range(10, 15)), int'($urandom_range(0, 15)) - 8);
      write_coef(int'($urandom_range(10, 15)), int'($urandom_range(0, 15)) - 8);
      for (int t = 0; t < 40; t++) begin
        enable   = ($urandom_range(0, 4) != 0);
        in_valid = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 9; i++) pix[i] = 8'($urandom_range(0, 255));
        step(1);
      end
      enable = 1'b1;
      in_valid = 1'b0;
      repeat (4) step(1);
      $display("random round %0d: shift=%0d done", r, sm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
